// File: rtl/divider_control_reg_if.sv
// Request/result bundle between the pipeline and the iterative divider.
// start is a one-cycle request sampled while busy is low; ready pulses once when results are valid.
interface divider_control_reg_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             ready;
    logic             div_by_zero;
    logic [1:0]       dbg_state;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, ready, div_by_zero, dbg_state
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, ready, div_by_zero, dbg_state
    );
endinterface

// File: rtl/divider_control_reg.sv
// Iterative signed divider: restoring division on magnitudes, one quotient bit per clock,
// with {remainder,quotient} kept in a single 2*WIDTH shift register.
module divider_control_reg #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    divider_control_reg_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t             state, state_next;
    logic [2*WIDTH-1:0] work, work_next;
    logic [WIDTH-1:0]   dvs, dvs_next;
    logic [CW-1:0]      count, count_next;
    logic               sign_q, sign_q_next;
    logic               sign_r, sign_r_next;
    logic [WIDTH-1:0]   quo, quo_next;
    logic [WIDTH-1:0]   rem, rem_next;
    logic               dbz, dbz_next;

    logic [2*WIDTH-1:0] shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] iter;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            work   <= '0;
            dvs    <= '0;
            count  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            quo    <= '0;
            rem    <= '0;
            dbz    <= 1'b0;
        end else begin
            state  <= state_next;
            work   <= work_next;
            dvs    <= dvs_next;
            count  <= count_next;
            sign_q <= sign_q_next;
            sign_r <= sign_r_next;
            quo    <= quo_next;
            rem    <= rem_next;
            dbz    <= dbz_next;
        end
    end

    // One restoring step: the extra top bit of trial is the borrow.
    always_comb begin
        shifted = {work[2*WIDTH-2:0], 1'b0};
        trial   = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, dvs};
        if (trial[WIDTH]) iter = shifted;
        else              iter = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    end

    always_comb begin
        state_next  = state;
        work_next   = work;
        dvs_next    = dvs;
        count_next  = count;
        sign_q_next = sign_q;
        sign_r_next = sign_r;
        quo_next    = quo;
        rem_next    = rem;
        dbz_next    = dbz;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_next = DONE;
                        dbz_next   = 1'b1;
                        quo_next   = '0;
                        rem_next   = bus.dividend;
                    end else begin
                        state_next  = RUN;
                        work_next   = {{WIDTH{1'b0}}, magnitude(bus.dividend)};
                        dvs_next    = magnitude(bus.divisor);
                        sign_q_next = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        sign_r_next = bus.dividend[WIDTH-1];
                        count_next  = '0;
                    end
                end
            end
            RUN: begin
                work_next  = iter;
                count_next = count + 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    // Results are registered on the way into DONE so they hold afterwards.
                    state_next = DONE;
                    dbz_next   = 1'b0;
                    quo_next   = sign_q ? (~iter[WIDTH-1:0] + 1'b1) : iter[WIDTH-1:0];
                    rem_next   = sign_r ? (~iter[2*WIDTH-1:WIDTH] + 1'b1) : iter[2*WIDTH-1:WIDTH];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy        = (state == RUN);
    assign bus.ready       = (state == DONE);
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_divider_control_reg.sv
// Directed bench for divider_control_reg: signed cases, divide-by-zero, overflow wrap,
// ignored start while busy and abort by clr.
module tb_divider_control_reg;
  localparam int W = 32;

  logic clk;
  logic clr;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];

  divider_control_reg_if #(.WIDTH(W)) bus ();

  divider_control_reg #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one op and follow it to ready, checking latency, busy span and results.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                        input int exp_lat, input bit repulse);
    int cyc;
    int busy_n;
    bit got;
    logic [W-1:0] wq;
    logic [W-1:0] wr;
    exp_q.push_back(eq);
    exp_q.push_back(er);
    busy_n = 0;
    got = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (repulse && cyc == 5) begin
        bus.start = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor = 32'd3;
      end else begin
        bus.start = 1'b0;
        bus.dividend = $urandom;
        bus.divisor = $urandom;
      end
      if (bus.busy) busy_n++;
      if (bus.ready) begin
        got = 1'b1;
        break;
      end
    end
    wq = exp_q.pop_front();
    wr = exp_q.pop_front();
    check({tag, " ready"}, W'(got), W'(1));
    check({tag, " latency"}, W'(cyc), W'(exp_lat));
    check({tag, " busy_cycles"}, W'(busy_n), W'(exp_lat - 1));
    check({tag, " quotient"}, bus.quotient, wq);
    check({tag, " remainder"}, bus.remainder, wr);
    check({tag, " div_by_zero"}, W'(bus.div_by_zero), W'(edbz));
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, " ready_pulse"}, W'(bus.ready), W'(0));
    check({tag, " hold_q"}, bus.quotient, wq);
    check({tag, " hold_r"}, bus.remainder, wr);
  endtask

  initial begin
    int saw_ready;
    checks = 0;
    errors = 0;
    clr = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst quotient", bus.quotient, '0);
    check("rst remainder", bus.remainder, '0);
    check("rst busy", W'(bus.busy), W'(0));
    check("rst ready", W'(bus.ready), W'(0));
    check("rst dbz", W'(bus.div_by_zero), W'(0));
    check("rst state", W'(bus.dbg_state), W'(0));
    clr = 1'b0;

    run_op("p100_7",  32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 1'b0);
    run_op("n100_7",  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 33, 1'b0);
    run_op("p100_n7", 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 33, 1'b0);
    run_op("n7_n2",   32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 33, 1'b0);
    run_op("p7_100",  32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 33, 1'b0);
    run_op("n1_1",    32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33, 1'b0);
    run_op("min_n1",  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33, 1'b0);
    run_op("dbz",     32'h12345678,   32'd0,          32'd0,          32'h12345678,   1'b1, 1,  1'b0);
    run_op("ignore",  32'd50,         32'd5,          32'd10,         32'd0,          1'b0, 33, 1'b1);

    // Abort: clr during RUN kills the op and clears every output.
    run_op("pre_abort", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("abort busy", W'(bus.busy), W'(0));
    check("abort quotient", bus.quotient, '0);
    check("abort remainder", bus.remainder, '0);
    check("abort dbz", W'(bus.div_by_zero), W'(0));
    saw_ready = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready || bus.busy) saw_ready++;
    end
    check("abort no_ready", W'(saw_ready), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
